// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small in-order fetch queue. A fetch PC drives a
// combinational instruction memory; fetched words queue up for decode.
module ifetch_queue #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic push;
  logic pop;
  logic wr_en;

  assign imem_addr = fpc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0) & ~redirect_valid;

  // Fullness is judged on the occupancy at the start of the cycle, so a pop
  // never frees a slot for a push in the same cycle.
  assign push  = ~redirect_valid & (count_q != CW'(DEPTH));
  assign pop   = out_valid & out_ready;
  assign wr_en = push & ~reset;

  assign out_pc    = out_valid ? pc_mem[head_q]    : '0;
  assign out_instr = out_valid ? instr_mem[head_q] : '0;

  always_comb begin
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset) begin
      fpc_d   = RESET_PC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (redirect_valid) begin
      fpc_d   = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fpc_d  = fpc_q + STEP;
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    fpc_q   <= fpc_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage is deliberately not reset; count/head/tail define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_q]    <= fpc_q;
      instr_mem[tail_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  logic [31:0] scramble = 32'h0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ scramble;

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .count          (count)
  );

  // Reference model: a plain FIFO of (pc, instr) pairs plus the fetch PC.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_fpc;
  logic [31:0] popped[$];

  logic        o_valid, e_valid;
  logic [31:0] o_pc, e_pc, o_instr, e_instr, o_addr, e_addr;
  logic [2:0]  o_count, e_count;

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit full;
    reset = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(negedge clk);
    o_valid = out_valid; o_pc = out_pc; o_instr = out_instr;
    o_count = count; o_addr = imem_addr;
    e_valid = (mq_pc.size() != 0) && !rv;
    e_pc    = e_valid ? mq_pc[0] : 32'h0;
    e_instr = e_valid ? mq_in[0] : 32'h0;
    e_count = 3'(mq_pc.size());
    e_addr  = m_fpc;
    if (o_valid === 1'b1 && rdy) popped.push_back(o_pc);
    @(posedge clk);
    #1;
    if (r) begin
      mq_pc.delete(); mq_in.delete(); m_fpc = 32'h0;
    end else if (rv) begin
      mq_pc.delete(); mq_in.delete(); m_fpc = rpc;
    end else begin
      full = (mq_pc.size() == 4);
      if (e_valid && rdy) begin
        void'(mq_pc.pop_front()); void'(mq_in.pop_front());
      end
      if (!full) begin
        mq_pc.push_back(m_fpc); mq_in.push_back(m_fpc ^ scramble);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    scramble = 32'h1234_5678;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if ({o_valid, o_pc, o_instr, o_count, o_addr} !== {1'b0, 32'h0, 32'h0, 3'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b pc=%h in=%h cnt=%0d addr=%h, want 0/0/0/0/0",
               o_valid, o_pc, o_instr, o_count, o_addr);
    end
  endtask

  task automatic test_streaming();
    scramble = 32'h0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (k >= 1) begin
        tests_run++;
        if ({o_valid, o_pc, o_instr, o_count} !== {1'b1, 32'(4*(k-1)), 32'(4*(k-1)), 3'd1}) begin
          tests_failed++;
          $display("FAIL streaming k=%0d: got v=%0b pc=%h in=%h cnt=%0d, want v=1 pc=in=%h cnt=1",
                   k, o_valid, o_pc, o_instr, o_count, 32'(4*(k-1)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    scramble = 32'hA5A5_0000;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      tests_run++;
      if (o_count !== 3'((k < 4) ? k : 4) || o_pc !== 32'h0 || o_addr !== 32'(4*((k < 4) ? k : 4))) begin
        tests_failed++;
        $display("FAIL backpressure_fill k=%0d: got cnt=%0d pc=%h addr=%h, want cnt=%0d pc=0 addr=%h",
                 k, o_count, o_pc, o_addr, (k < 4) ? k : 4, 32'(4*((k < 4) ? k : 4)));
      end
    end
    popped.delete();
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (popped.size() <= i || popped[i] !== 32'(4*i)) begin
        tests_failed++;
        $display("FAIL backpressure_drain i=%0d: got %h, want %h",
                 i, (popped.size() > i) ? popped[i] : 32'hx, 32'(4*i));
      end
    end
  endtask

  task automatic test_redirect();
    scramble = 32'h0F0F_0F0F;
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    tests_run++;
    if (o_valid !== 1'b0 || o_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL redirect_cycle: got v=%0b cnt=%0d, want v=0 cnt=3", o_valid, o_count);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (o_count !== 3'd0 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_next: got cnt=%0d addr=%h v=%0b, want 0/100/0", o_count, o_addr, o_valid);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== (32'h100 ^ scramble)) begin
      tests_failed++;
      $display("FAIL redirect_head: got v=%0b pc=%h in=%h, want 1/100/%h",
               o_valid, o_pc, o_instr, 32'h100 ^ scramble);
    end
  endtask

  task automatic test_wrap();
    scramble = 32'h0;
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    popped.delete();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (popped.size() < 2 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap: got %h,%h, want fffffffc,00000000",
               (popped.size() > 0) ? popped[0] : 32'hx, (popped.size() > 1) ? popped[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    scramble = 32'h0;
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (o_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL reset_mid_full: got cnt=%0d, want 4", o_count);
    end
    cycle(1'b1, 1'b1, 32'h200, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (o_count !== 3'd0 || o_addr !== 32'h0 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got cnt=%0d addr=%h v=%0b, want 0/00000000/0", o_count, o_addr, o_valid);
    end
  endtask

  task automatic test_push_pop();
    scramble = 32'h0;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    popped.delete();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      tests_run++;
      if (o_count !== 3'd2) begin
        tests_failed++;
        $display("FAIL push_pop_count k=%0d: got %0d, want 2", k, o_count);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (popped.size() <= i || popped[i] !== 32'(4*i)) begin
        tests_failed++;
        $display("FAIL push_pop_order i=%0d: got %h, want %h",
                 i, (popped.size() > i) ? popped[i] : 32'hx, 32'(4*i));
      end
    end
  endtask

  task automatic test_random();
    logic        r, rv, rdy;
    logic [31:0] rpc;
    scramble = $urandom;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      cycle(r, rv, rpc, rdy);
      tests_run++;
      if ({o_valid, o_pc, o_instr, o_count, o_addr} !== {e_valid, e_pc, e_instr, e_count, e_addr}) begin
        tests_failed++;
        $display("FAIL random k=%0d: got v=%0b pc=%h in=%h cnt=%0d addr=%h, want v=%0b pc=%h in=%h cnt=%0d addr=%h",
                 k, o_valid, o_pc, o_instr, o_count, o_addr, e_valid, e_pc, e_instr, e_count, e_addr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    m_fpc = 32'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-004 SHALL have parameter PC_STEP, default 4: sequential PC increment.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port redirect_valid  input  1  branch/exception redirect request.
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-009 SHALL have port imem_addr  output  XLEN  instruction-memory address; combinational memory returns data the same cycle.
REQ-010 SHALL have port imem_data  input  32  instruction word at imem_addr.
REQ-011 SHALL have port out_valid  output  1  head entry available to decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts head entry.
REQ-013 SHALL have port out_pc  output  XLEN  PC of head entry.
REQ-014 SHALL have port out_instr  output  32  instruction of head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 SHALL hold fetch PC register fpc; imem_addr SHALL equal fpc combinationally.
REQ-017 SHALL push, when redirect_valid=0 and count<DEPTH: write {fpc, imem_data} at tail; fpc <= fpc+PC_STEP, modulo 2^XLEN.
REQ-018 SHALL, when count==DEPTH and redirect_valid=0: no push; fpc holds. A same-cycle pop SHALL NOT enable a push in that cycle.
REQ-019 SHALL drive out_valid = (count!=0) & ~redirect_valid.
REQ-020 SHALL pop, when out_valid & out_ready: head pointer advances; pushed data is visible at the head no earlier than the cycle after its push, giving 1-cycle fetch-to-decode latency.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-022 SHALL wrap head and tail pointers modulo DEPTH; entries SHALL emerge strictly in push order.
REQ-023 SHALL, on redirect_valid=1 with reset=0: set count, head and tail to 0; set fpc <= redirect_pc; perform no push and no pop that cycle.
REQ-024 SHALL fetch redirect_pc in the cycle after the redirect; its entry reaches out_valid=1 two cycles after the redirect cycle.
REQ-025 SHALL apply the later redirect's target on back-to-back redirects; each redirect re-flushes.
REQ-026 SHALL drive out_pc=0 and out_instr=0 whenever out_valid=0.
REQ-027 SHALL keep out_pc, out_instr and out_valid stable while out_valid=1 and out_ready=0, absent a redirect.

Reset
REQ-028 SHALL, while reset=1 at a clock edge: set fpc <= RESET_PC; count, head and tail <= 0; no push or pop. Reset SHALL dominate redirect_valid.
REQ-029 SHALL drive out_valid=0, out_pc=0, out_instr=0, count=0 and imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-030 SHALL discard all queued entries on reset asserted mid-stream; queue storage need not be cleared.

Verification
REQ-031 SHALL verify streaming: reset, out_ready=1, memory word = address -> out_pc/out_instr = 0,4,8,... in consecutive cycles from cycle 2 after reset; count holds at 1.
REQ-032 SHALL verify backpressure fill: out_ready=0 for 8 cycles -> count reaches 4 and saturates; imem_addr holds at 16; out_pc stays 0; on out_ready=1, PCs 0,4,8,12,16 emerge in order.
REQ-033 SHALL verify redirect flush: at count=3, redirect_valid=1 with redirect_pc=32'h100 -> out_valid=0 that cycle; next cycle count=0 and imem_addr=32'h100; the following cycle out_pc=32'h100.
REQ-034 SHALL verify PC wrap: redirect_pc=32'hFFFF_FFFC -> entries FFFF_FFFC then 0000_0000.
REQ-035 SHALL verify reset mid-operation: reset=1 and redirect_valid=1 together with count=4 -> next cycle count=0, imem_addr=RESET_PC.
REQ-036 SHALL verify simultaneous push/pop at count=2 over 10 cycles -> count stays 2 and no PC is skipped or duplicated.
